// File: rtl/clk_div_pkg.sv
// Shared definitions for the fractional clock divider.
// Contents:
//   CNT_W_DEF   default width of the integer divisor field
//   H_MIN       shortest output period in sys_clk half-cycles (divide-by-1)
//   HC_EXTRA    extra bits the half-cycle counter needs beyond the divisor width
//   HC_W_DEF    half-cycle counter width for the default divisor width
//   run_state_e divider core mode: idle (output parked low) or running
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int H_MIN     = 2;
  localparam int HC_EXTRA  = 2;
  localparam int HC_W_DEF  = CNT_W_DEF + HC_EXTRA;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_e;

endpackage

// File: rtl/clk_div_rst_sync.sv
// Two-stage reset synchroniser: asserts asynchronously with sys_rst_n and
// releases on the second sys_clk posedge after sys_rst_n rises.
// Ports:
//   sys_clk       system clock
//   sys_rst_n     raw asynchronous active-low reset
//   rst_sync_n_o  reset for the divider core, release aligned to sys_clk
module clk_div_rst_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic rst_sync_n_o
);

  logic [1:0] sync_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n_o = sync_q[1];

endmodule

// File: rtl/clk_div_frac.sv
// Fractional clock divider with half-cycle resolution.
// The output period is H = 2*div_int + div_half sys_clk half-cycles; clk_out
// is high for ceil(H/2) half-cycles and low for floor(H/2).
// Ports:
//   sys_clk      system clock (both edges used)
//   sys_rst_n    asynchronous active-low reset
//   en           output enable; dropping it finishes the current period
//   div_int      integer part of the divide ratio (0 is illegal -> H=2)
//   div_half     adds half a sys_clk cycle to the period
//   cfg_load     one-cycle pulse capturing div_int/div_half into the shadow
//   clk_out      divided clock
//   div_tick     one-cycle pulse per output period
//   cfg_pending  shadow configuration waiting for the next period boundary
//   cfg_err      sticky flag, set when div_int=0 is captured
//
// Output construction: each sys_clk cycle is two half-cycle slots. The
// posedge logic decides the level of both slots. p_q (posedge flop) and n_q
// (negedge flop) are combined with XOR; only one of them can change at any
// clock edge, so clk_out cannot glitch and never pulses shorter than a slot.
module clk_div_frac
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_INT  = 1,
  parameter int DEF_HALF = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_int,
  input  logic             div_half,
  input  logic             cfg_load,
  output logic             clk_out,
  output logic             div_tick,
  output logic             cfg_pending,
  output logic             cfg_err
);

  localparam int HC_W = CNT_W + HC_EXTRA;

  // Substitute configuration for an illegal div_int of zero.
  localparam logic [CNT_W-1:0] SUB_INT  = CNT_W'(H_MIN / 2);
  localparam logic             SUB_HALF = 1'(H_MIN % 2);
  localparam logic [CNT_W-1:0] RST_INT  = (DEF_INT == 0) ? SUB_INT : CNT_W'(DEF_INT);
  localparam logic             RST_HALF = (DEF_INT == 0) ? SUB_HALF : 1'(DEF_HALF);

  function automatic logic [HC_W-1:0] period_of(input logic [CNT_W-1:0] i,
                                                input logic             h);
    return {1'b0, i, 1'b0} + HC_W'(h);
  endfunction

  // Number of high slots in a period of h slots: ceil(h/2).
  function automatic logic [HC_W-1:0] hi_len(input logic [HC_W-1:0] h);
    return (h + HC_W'(1)) >> 1;
  endfunction

  logic rst_core_n;

  clk_div_rst_sync u_rst_sync (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .rst_sync_n_o (rst_core_n)
  );

  run_state_e       state_q, state_d;
  logic [HC_W-1:0]  pos_q, pos_d;
  logic [CNT_W-1:0] act_int_q, act_int_d, shd_int_q;
  logic             act_half_q, act_half_d, shd_half_q;
  logic             pend_q, pend_d, err_q;
  logic             p_q, p_d, n_q;
  logic             d_odd_q, d_odd_d;
  logic             odd_start_q, odd_start_d;
  logic             tick_q, tick_d;

  logic [HC_W-1:0]  h_act, h_shd, h_e, h_o, pos_e, pos_o, pos_n;
  logic             bnd_e, stop_odd, apply, d_even;

  assign h_act = period_of(act_int_q, act_half_q);
  assign h_shd = period_of(shd_int_q, shd_half_q);

  // Shadow capture. The illegal zero divisor is replaced so the output keeps
  // running at divide-by-1.
  // NOTE: the shadow is configuration state, not bulk storage, so it gets a
  // defined reset value like every other control register.
  always_ff @(posedge sys_clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      shd_int_q  <= RST_INT;
      shd_half_q <= RST_HALF;
      err_q      <= 1'b0;
    end else if (cfg_load) begin
      if (div_int == '0) begin
        shd_int_q  <= SUB_INT;
        shd_half_q <= SUB_HALF;
        err_q      <= 1'b1;
      end else begin
        shd_int_q  <= div_int;
        shd_half_q <= div_half;
      end
    end
  end

  // Per-cycle schedule. pos_q is the position, within the current period,
  // of this cycle's posedge slot; the negedge slot is pos+1. A period may
  // therefore start on either slot, and a pending shadow is applied exactly
  // when a period starts.
  // NOTE: every combinational output gets a default first so no path leaves
  // a signal unassigned (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    act_int_d   = act_int_q;
    act_half_d  = act_half_q;
    apply       = 1'b0;
    d_even      = 1'b0;
    d_odd_d     = 1'b0;
    odd_start_d = 1'b0;
    tick_d      = odd_start_q;   // a rise on the previous negedge ticks now
    h_e         = h_act;
    h_o         = h_act;
    pos_e       = pos_q;
    pos_o       = '0;
    pos_n       = '0;
    stop_odd    = 1'b0;
    bnd_e       = (state_q == ST_IDLE) || (pos_q == '0);

    if (bnd_e && !en) begin
      state_d = ST_IDLE;
      pos_d   = '0;
    end else begin
      if (bnd_e) begin
        pos_e  = '0;
        tick_d = 1'b1;
        if (pend_q) begin
          apply      = 1'b1;
          act_int_d  = shd_int_q;
          act_half_d = shd_half_q;
          h_e        = h_shd;
        end
      end
      d_even = (pos_e < hi_len(h_e));
      pos_o  = pos_e + 1'b1;
      h_o    = h_e;

      // Period ends after the posedge slot: next period starts on negedge.
      if (pos_o == h_e) begin
        if (en) begin
          odd_start_d = 1'b1;
          pos_o       = '0;
          if (pend_q) begin
            apply      = 1'b1;
            act_int_d  = shd_int_q;
            act_half_d = shd_half_q;
            h_o        = h_shd;
          end
        end else begin
          stop_odd = 1'b1;
        end
      end

      if (stop_odd) begin
        state_d = ST_IDLE;
        pos_d   = '0;
      end else begin
        d_odd_d = (pos_o < hi_len(h_o));
        pos_n   = pos_o + 1'b1;
        pos_d   = (pos_n == h_o) ? '0 : pos_n;
        state_d = ST_RUN;
      end
    end

    // A load coinciding with a boundary keeps pending set for the new value.
    pend_d = cfg_load ? 1'b1 : (apply ? 1'b0 : pend_q);
    p_d    = d_even ^ n_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge sys_clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      act_int_q   <= RST_INT;
      act_half_q  <= RST_HALF;
      pend_q      <= 1'b0;
      p_q         <= 1'b0;
      d_odd_q     <= 1'b0;
      odd_start_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      act_int_q   <= act_int_d;
      act_half_q  <= act_half_d;
      pend_q      <= pend_d;
      p_q         <= p_d;
      d_odd_q     <= d_odd_d;
      odd_start_q <= odd_start_d;
      tick_q      <= tick_d;
    end
  end

  // Negedge half: chosen so that p_q ^ n_q equals the planned level of the
  // second slot of the cycle.
  always_ff @(negedge sys_clk or negedge rst_core_n) begin
    if (!rst_core_n) begin
      n_q <= 1'b0;
    end else begin
      n_q <= d_odd_q ^ p_q;
    end
  end

  assign clk_out     = p_q ^ n_q;
  assign div_tick    = tick_q;
  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_clk_div_frac.sv
// Self-checking bench for clk_div_frac. A period-level reference model turns
// each cycle's stimulus into expected (high, low) slot counts and expected
// status flags; a monitor measures clk_out per half-cycle and compares.
module tb_clk_div_frac;

  localparam int CNT_W = 8;
  localparam int N_CYC = 1600;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] div_int = '0;
  logic             div_half = 1'b0;
  logic             cfg_load = 1'b0;
  logic             clk_out, div_tick, cfg_pending, cfg_err;

  clk_div_frac #(.CNT_W(CNT_W), .DEF_INT(1), .DEF_HALF(1)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .en          (en),
    .div_int     (div_int),
    .div_half    (div_half),
    .cfg_load    (cfg_load),
    .clk_out     (clk_out),
    .div_tick    (div_tick),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { int hi; int lo; } period_t;
  typedef struct { int pend; int err; } status_t;
  period_t exp_q[$];
  status_t st_q[$];
  bit      sb_on = 1'b0;
  int      cyc = 0;
  int      rel_cyc = 0;
  int      periods_checked = 0;
  bit      first_seen = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Reference model, period level. A period starting at half-cycle slot b
  // is decided at posedge floor(b/2); loads captured at earlier posedges
  // are eligible, the last one wins. Slot 2j is posedge j after release.
  int m_act_int, m_act_half, m_shd_int, m_shd_half, m_pend, m_err, m_next;

  task automatic model_reset();
    m_act_int = 1; m_act_half = 1; m_shd_int = 1; m_shd_half = 1;
    m_pend = 0; m_err = 0;
    m_next = 6;   // first rise at the 3rd posedge after release
  endtask

  task automatic model_step(input int j, input bit ld, input int di, input bit dh);
    int h;
    if (m_next / 2 == j) begin
      if (m_pend != 0) begin
        m_act_int  = m_shd_int;
        m_act_half = m_shd_half;
        m_pend     = 0;
      end
      h = 2 * m_act_int + m_act_half;
      exp_q.push_back('{(h + 1) / 2, h / 2});
      m_next += h;
    end
    if (ld) begin
      if (di == 0) begin
        m_shd_int = 1; m_shd_half = 0; m_err = 1;
      end else begin
        m_shd_int = di; m_shd_half = dh;
      end
      m_pend = 1;
    end
    st_q.push_back('{m_pend, m_err});
  endtask

  // Monitor: one sample per half-cycle slot.
  initial begin
    bit lvl, prev_lvl, rise, rise_prev, in_per, is_pos;
    int hi, lo;
    period_t ep;
    status_t es;
    prev_lvl = 0; rise_prev = 0; in_per = 0; hi = 0; lo = 0;
    forever begin
      @(posedge sys_clk or negedge sys_clk);
      #1;
      if (!sb_on) begin
        in_per = 0; rise_prev = 0; prev_lvl = clk_out;
      end else begin
        lvl    = clk_out;
        is_pos = sys_clk;
        rise   = lvl && !prev_lvl;
        if (is_pos) begin
          if (st_q.size() == 0) begin
            check("status_queue_empty", 0, 1);
          end else begin
            es = st_q.pop_front();
            check("cfg_pending", cfg_pending, es.pend);
            check("cfg_err", cfg_err, es.err);
          end
          check("div_tick", div_tick, (rise || rise_prev) ? 1 : 0);
        end
        if (rise) begin
          if (!first_seen) begin
            first_seen = 1;
            check("first_rise_posedge", is_pos ? (cyc - rel_cyc) : -1, 3);
          end
          if (in_per) begin
            if (exp_q.size() == 0) begin
              check("period_queue_empty", 0, 1);
            end else begin
              ep = exp_q.pop_front();
              check("high_slots", hi, ep.hi);
              check("low_slots", lo, ep.lo);
              periods_checked++;
            end
          end
          in_per = 1; hi = 1; lo = 0;
        end else if (in_per) begin
          if (lvl) hi++; else lo++;
        end
        rise_prev = rise;
        prev_lvl  = lvl;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ld, dh, prev, found;
    int di, hcnt, rises;
    bit exp_lvl [6] = '{1, 0, 1, 1, 0, 1};

    // Reset state.
    en = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("rst_clk_out", clk_out, 0);
    check("rst_div_tick", div_tick, 0);
    check("rst_cfg_pending", cfg_pending, 0);
    check("rst_cfg_err", cfg_err, 0);

    // Scoreboard phase: directed loads first, then random traffic.
    model_reset();
    sys_rst_n = 1'b1;
    rel_cyc   = cyc;
    sb_on     = 1'b1;
    for (int j = 1; j <= N_CYC; j++) begin
      ld = 0; di = 0; dh = 0;
      case (j)
        10:  begin ld = 1; di = 4; dh = 0; end
        40:  begin ld = 1; di = 3; dh = 0; end
        70:  begin ld = 1; di = 4; dh = 0; end
        95:  begin ld = 1; di = 2; dh = 1; end
        130: begin ld = 1; di = 0; dh = 1; end
        150: begin ld = 1; di = 5; dh = 1; end
        151: begin ld = 1; di = 2; dh = 0; end
        default: begin
          if (j >= 170 && $urandom_range(0, 7) == 0) begin
            ld = 1;
            di = $urandom_range(0, 5);
            dh = 1'($urandom_range(0, 1));
          end
        end
      endcase
      cfg_load = ld;
      div_int  = CNT_W'(di);
      div_half = dh;
      model_step(j, ld, di, dh);
      @(posedge sys_clk);
      @(negedge sys_clk);
      cfg_load = 1'b0;
    end
    check("periods_observed", (periods_checked >= 150) ? 1 : 0, 1);
    check("first_rise_observed", first_seen, 1);
    sb_on = 1'b0;
    exp_q.delete();
    st_q.delete();

    // Enable off: output parks low, load waits for the next period start.
    @(negedge sys_clk);
    en = 1'b0; cfg_load = 1'b1; div_int = 8'd4; div_half = 1'b0;
    @(negedge sys_clk);
    cfg_load = 1'b0;
    repeat (20) @(negedge sys_clk);
    #1;
    check("en_off_idle_low", clk_out, 0);
    check("pend_held_while_idle", cfg_pending, 1);

    // Enable on: rise at the next posedge, 4/0 applied there.
    en = 1'b1;
    @(posedge sys_clk);
    #1;
    check("en_on_rise", clk_out, 1);
    check("en_on_pend_clear", cfg_pending, 0);
    check("en_on_tick", div_tick, 1);

    // Drop en mid-high: the 4-slot high phase completes, then stays low.
    @(negedge sys_clk);
    #1;
    en = 1'b0;
    hcnt = clk_out; rises = 0; prev = clk_out;
    for (int i = 0; i < 15; i++) begin
      @(posedge sys_clk or negedge sys_clk);
      #1;
      if (clk_out) hcnt++;
      if (clk_out && !prev) rises++;
      prev = clk_out;
    end
    check("en_drop_high_slots", hcnt, 3);
    check("en_drop_no_rise", rises, 0);

    // Reset asserted mid-high with a pending load.
    @(negedge sys_clk);
    en = 1'b1;
    @(posedge sys_clk);
    #1;
    check("restart_rise", clk_out, 1);
    @(negedge sys_clk);
    cfg_load = 1'b1; div_int = 8'd3; div_half = 1'b0;
    @(posedge sys_clk);
    #1;
    cfg_load = 1'b0;
    check("pre_rst_pending", cfg_pending, 1);
    check("pre_rst_high", clk_out, 1);
    check("err_sticky", cfg_err, 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_clk_out", clk_out, 0);
    check("mid_rst_pending", cfg_pending, 0);
    check("mid_rst_err", cfg_err, 0);
    check("mid_rst_tick", div_tick, 0);

    // Release: defaults return, pending load discarded.
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    check("rerelease_pre_rise", clk_out, 0);
    @(posedge sys_clk);
    #1;
    check("rerelease_rise_3rd", clk_out, 1);
    found = 1;
    for (int s = 0; s < 6; s++) begin
      @(posedge sys_clk or negedge sys_clk);
      #1;
      if (clk_out !== exp_lvl[s]) found = 0;
      check("default_wave", clk_out, exp_lvl[s]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/clk_div_frac.md
CLK_DIV_FRAC -- requirements
Module: clk_div_frac

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the integer divisor field.
REQ-002 SHALL have parameter DEF_INT, default 1: integer divisor after reset.
REQ-003 SHALL have parameter DEF_HALF, default 1: half-step flag after reset (1 gives divide-by-1.5).
REQ-004 SHALL have port sys_clk  input  1  system clock; the only clock, both edges used.
REQ-005 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  output clock enable.
REQ-007 SHALL have port div_int  input  CNT_W  integer part of the divide ratio.
REQ-008 SHALL have port div_half  input  1  adds 0.5 to the divide ratio.
REQ-009 SHALL have port cfg_load  input  1  one-cycle pulse that captures div_int and div_half.
REQ-010 SHALL have port clk_out  output  1  divided clock.
REQ-011 SHALL have port div_tick  output  1  one-sys_clk pulse per output period.
REQ-012 SHALL have port cfg_pending  output  1  captured configuration not yet applied.
REQ-013 SHALL have port cfg_err  output  1  sticky flag for illegal configuration.

Function
REQ-014 SHALL define the period in sys_clk half-cycles as H = 2*div_int + div_half, taken from the active configuration.
REQ-015 SHALL drive clk_out high for ceil(H/2) half-cycles, then low for floor(H/2) half-cycles.
- Even H gives exact 50% duty, including odd integer ratios.
REQ-016 SHALL build clk_out only from flops clocked on posedge and negedge sys_clk, combined glitch-free.
- No clock multiplexer.
- No pulse narrower than one half-cycle.
REQ-017 SHALL, on cfg_load high at a sys_clk posedge, capture div_int and div_half into a shadow register and set cfg_pending on the next posedge.
REQ-018 SHALL copy the shadow to the active configuration only at a period boundary (rising edge of clk_out), then clear cfg_pending within one sys_clk cycle.
REQ-019 SHALL let a cfg_load arriving while cfg_pending=1 overwrite the shadow; only the last value is applied.
REQ-020 SHALL, when cfg_load coincides with a period boundary, apply the previous shadow and keep cfg_pending=1 for the new value.
REQ-021 SHALL treat div_int=0 as illegal: set cfg_err=1 at capture and apply H=2 (divide-by-1).
REQ-022 SHALL clear cfg_err only by reset.
REQ-023 SHALL, when div_int=1 and div_half=0, produce clk_out at sys_clk frequency (H=2).
REQ-024 SHALL, on en deasserting, complete the current output period, then hold clk_out low with no partial pulse.
REQ-025 SHALL, on en reasserting, start a new period with a rising edge at the next sys_clk posedge.
REQ-026 SHALL assert div_tick for exactly one cycle at the first sys_clk posedge at or after each clk_out rising edge.
- Half-integer ratios therefore give uneven tick spacing.

Reset
REQ-027 SHALL, while sys_rst_n=0, force clk_out=0, div_tick=0, cfg_pending=0, cfg_err=0, counters to 0, active config and shadow to DEF_INT/DEF_HALF, asynchronously.
REQ-028 SHALL synchronise reset deassertion internally with a two-stage synchroniser.
- With en=1, the first clk_out rising edge occurs at the 3rd sys_clk posedge after sys_rst_n rises.
REQ-029 SHALL, on reset asserted mid-period, drive clk_out low immediately and discard any pending configuration.

Structure
REQ-030 SHALL place CNT_W default, minimum H (2) and the half-cycle counter width (CNT_W+2) in a shared package clk_div_pkg.
REQ-031 SHALL implement the reset synchroniser as sub-module clk_div_rst_sync.
- The divider core stays in clk_div_frac.

Verification
REQ-032 SHALL check reset defaults (1/1): clk_out period 1.5 sys_clk, high 1.0 cycle, low 0.5 cycle; first rise at the 3rd posedge after release.
REQ-033 SHALL check div_int=4, div_half=0: period 4 cycles, high exactly 2 cycles, div_tick every 4 cycles.
REQ-034 SHALL check div_int=3, div_half=0: period 3 cycles, high 1.5 cycles.
REQ-035 SHALL check a load of 2/1 issued mid-period while running 4/0.
- The current 4-cycle period completes, then 2.5-cycle periods follow (high 1.5, low 1.0).
- cfg_pending falls at that boundary.
REQ-036 SHALL check cfg_load with div_int=0: cfg_err=1 and sticky, clk_out equals sys_clk rate.
REQ-037 SHALL check en dropped mid-high-phase: the period finishes, then clk_out stays low; reset asserted mid-high drives clk_out=0 immediately.
